// File: rtl/fpu_issue_ctrl.sv
// FPU issue and sequencing controller.
// Takes one FP op per valid/ready handshake, holds operands stable for the
// selected unit, pulses it, waits for done (with timeout) and produces a
// one-cycle registered writeback.
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        g_clk,
  input  logic        g_rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_op,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [31:0] issue_c,
  input  logic        flush,
  output logic        unit_start,
  output logic [3:0]  unit_sel,
  output logic [1:0]  unit_fma_sel,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic [31:0] unit_c,
  input  logic        unit_done,
  input  logic [31:0] unit_result,
  input  logic [31:0] comb_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        timeout_err
);

  localparam logic [31:0] CanonNan    = 32'h7fc0_0000;
  localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StComb, StStart, StWait, StDrain} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q;
  logic        inv_q;
  logic [3:0]  sel_q;
  logic [1:0]  fma_q;
  logic [31:0] a_q, b_q, c_q;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  dec_sel;
  logic        dec_multi;
  logic        dec_invalid;
  logic        accept;

  assign issue_ready  = (state_q == StIdle) && !flush;
  assign stall        = ~issue_ready;
  assign accept       = issue_valid && issue_ready;
  assign unit_start   = (state_q == StStart);
  assign unit_sel     = sel_q;
  assign unit_fma_sel = fma_q;
  assign unit_a       = a_q;
  assign unit_b       = b_q;
  assign unit_c       = c_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign timeout_err  = timeout_q;

  // Opcode classification and unit select decode.
  always_comb begin
    dec_sel     = 4'd0;
    dec_multi   = (issue_op[4:3] == 2'b10) || (issue_op[4:2] == 3'b000);
    dec_invalid = (issue_op == 5'b00100) || (issue_op[4:3] == 2'b11);
    if (issue_op[4:3] == 2'b10) begin
      case (issue_op[2:0])
        3'd4:    dec_sel = 4'd5;
        3'd5:    dec_sel = 4'd7;
        3'd6:    dec_sel = 4'd4;
        3'd7:    dec_sel = 4'd6;
        default: dec_sel = 4'd8;
      endcase
    end else if (issue_op[4:2] == 3'b000) begin
      case (issue_op[1:0])
        2'd2:    dec_sel = 4'd2;
        2'd3:    dec_sel = 4'd3;
        default: dec_sel = 4'd1;
      endcase
    end
  end

  // Next-state, wait counter and writeback decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = dec_multi ? StStart : StComb;
      end
      StComb: begin
        if (!flush) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = inv_q ? CanonNan : comb_result;
        end
        state_d = StIdle;
      end
      StStart: begin
        cnt_d   = 8'd0;
        state_d = flush ? StDrain : StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (flush) begin
          // A done racing the flush is dropped; nothing left to drain.
          state_d = unit_done ? StIdle : StDrain;
        end else if (unit_done) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = unit_result;
          state_d    = StIdle;
        end else if (cnt_q >= TimeoutLast) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = CanonNan;
          timeout_d  = 1'b1;
          state_d    = StIdle;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 8'd1;
        if (unit_done) begin
          state_d = StIdle;
        end else if (cnt_q >= TimeoutLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and registered writeback.
  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      timeout_q  <= timeout_d;
    end
  end

  // Operand capture on accept; held until the next accept.
  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      rd_q  <= 5'd0;
      inv_q <= 1'b0;
      sel_q <= 4'd0;
      fma_q <= 2'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      c_q   <= 32'd0;
    end else if (accept) begin
      rd_q  <= issue_rd;
      inv_q <= dec_invalid;
      sel_q <= dec_sel;
      fma_q <= issue_op[1:0];
      a_q   <= issue_a;
      // fsub is fed to the adder as a + (-b).
      b_q   <= (issue_op == 5'b00001) ? {~issue_b[31], issue_b[30:0]} : issue_b;
      c_q   <= issue_c;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: writebacks are checked against a
// scoreboard queue; per-scenario tasks check timing and control outputs.
module tb_fpu_issue_ctrl;

  localparam int unsigned To = 8;

  logic        g_clk = 1'b0;
  logic        g_rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_op = 5'd0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] issue_a = 32'd0, issue_b = 32'd0, issue_c = 32'd0;
  logic        flush = 1'b0;
  logic        unit_start;
  logic [3:0]  unit_sel;
  logic [1:0]  unit_fma_sel;
  logic [31:0] unit_a, unit_b, unit_c;
  logic        unit_done = 1'b0;
  logic [31:0] unit_result = 32'd0;
  logic [31:0] comb_result = 32'd0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        timeout_err;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        to;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;
  int  starts = 0;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(To)) dut (
    .g_clk        (g_clk),
    .g_rst_n      (g_rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_rd     (issue_rd),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_c      (issue_c),
    .flush        (flush),
    .unit_start   (unit_start),
    .unit_sel     (unit_sel),
    .unit_fma_sel (unit_fma_sel),
    .unit_a       (unit_a),
    .unit_b       (unit_b),
    .unit_c       (unit_c),
    .unit_done    (unit_done),
    .unit_result  (unit_result),
    .comb_result  (comb_result),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall        (stall),
    .timeout_err  (timeout_err)
  );

  always #5 g_clk = ~g_clk;

  // Writeback monitor: every pulse must match the head of the scoreboard.
  always @(negedge g_clk) begin
    if (g_rst_n && unit_start) starts++;
    if (g_rst_n && wb_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h to=%b, required no writeback",
                 wb_rd, wb_data, timeout_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wb_rd, wb_data, timeout_err} !== mon_e) begin
          miscompares++;
          $display("FAIL wb_data: got rd=%0d data=%h to=%b, required rd=%0d data=%h to=%b",
                   wb_rd, wb_data, timeout_err, mon_e.rd, mon_e.data, mon_e.to);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // Presents one op and completes the handshake; returns in cycle k+1.
  task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, output logic wbv);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rd    = rd;
    issue_a     = a;
    issue_b     = b;
    issue_c     = c;
    @(negedge g_clk);
    wbv = wb_valid;
    vectors++;
    if (issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: got %b, required 1", issue_ready);
    end
    step();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    g_rst_n = 1'b0;
    issue_valid = 1'b1;
    repeat (2) @(negedge g_clk);
    vectors++;
    if (issue_ready !== 1'b1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got ready=%b stall=%b, required 1/0", issue_ready, stall);
    end
    vectors++;
    if ({unit_a, unit_b, unit_c} !== 96'd0 || unit_sel !== 4'd0 || unit_fma_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_unit: got sel=%0d fma=%0d a=%h, required zeros",
               unit_sel, unit_fma_sel, unit_a);
    end
    vectors++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_wb: got v=%b rd=%0d data=%h, required zeros", wb_valid, wb_rd, wb_data);
    end
    vectors++;
    if (unit_start !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got start=%b to=%b, required 0/0", unit_start, timeout_err);
    end
    issue_valid = 1'b0;
    step();
    g_rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_cycle();
    int   s0;
    logic wbv;
    s0 = starts;
    comb_result = 32'd1;
    exp_q.push_back('{rd: 5'd3, data: 32'd1, to: 1'b0});
    issue(5'b01010, 5'd3, 32'h1, 32'h2, 32'h3, wbv);
    @(negedge g_clk);
    vectors++;
    if (wb_valid !== 1'b0 || stall !== 1'b1 || unit_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_k1: got wb=%b stall=%b start=%b, required 0/1/0",
               wb_valid, stall, unit_start);
    end
    step();
    // Back-to-back: the second op is accepted in the cycle the first writes back.
    comb_result = 32'h0000_abcd;
    exp_q.push_back('{rd: 5'd12, data: 32'h0000_abcd, to: 1'b0});
    issue(5'b00101, 5'd12, 32'h4, 32'h5, 32'h6, wbv);
    vectors++;
    if (wbv !== 1'b1) begin
      miscompares++;
      $display("FAIL single_wb_k2: got wb_valid=%b, required 1", wbv);
    end
    @(negedge g_clk);
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wb_width: got wb_valid=%b, required 0", wb_valid);
    end
    step();
    @(negedge g_clk);
    vectors++;
    if (wb_valid !== 1'b1 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_wb: got wb=%b ready=%b, required 1/1", wb_valid, issue_ready);
    end
    step();
    vectors++;
    if (starts !== s0) begin
      miscompares++;
      $display("FAIL single_no_start: got %0d start pulses, required 0", starts - s0);
    end
  endtask

  task automatic test_fsub();
    int   s0;
    logic wbv;
    s0 = starts;
    exp_q.push_back('{rd: 5'd4, data: 32'hbf80_0000, to: 1'b0});
    issue(5'b00001, 5'd4, 32'h3f80_0000, 32'h4000_0000, 32'h0, wbv);
    @(negedge g_clk);
    vectors++;
    if (unit_start !== 1'b1 || unit_sel !== 4'd1 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL fsub_start: got start=%b sel=%0d stall=%b, required 1/1/1",
               unit_start, unit_sel, stall);
    end
    vectors++;
    if (unit_b !== 32'hc000_0000 || unit_a !== 32'h3f80_0000) begin
      miscompares++;
      $display("FAIL fsub_operands: got a=%h b=%h, required 3f800000/c0000000", unit_a, unit_b);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge g_clk);
      vectors++;
      if (stall !== 1'b1 || unit_start !== 1'b0) begin
        miscompares++;
        $display("FAIL fsub_wait%0d: got stall=%b start=%b, required 1/0", i, stall, unit_start);
      end
    end
    step();
    unit_done   = 1'b1;
    unit_result = 32'hbf80_0000;
    @(negedge g_clk);
    vectors++;
    if (stall !== 1'b1 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fsub_done_cycle: got stall=%b wb=%b, required 1/0", stall, wb_valid);
    end
    step();
    unit_done = 1'b0;
    @(negedge g_clk);
    vectors++;
    if (wb_valid !== 1'b1 || issue_ready !== 1'b1 || unit_b !== 32'hc000_0000) begin
      miscompares++;
      $display("FAIL fsub_wb: got wb=%b ready=%b b=%h, required 1/1/c0000000",
               wb_valid, issue_ready, unit_b);
    end
    step();
    vectors++;
    if (starts !== s0 + 1) begin
      miscompares++;
      $display("FAIL fsub_start_count: got %0d, required 1", starts - s0);
    end
  endtask

  task automatic test_fma();
    logic wbv;
    exp_q.push_back('{rd: 5'd20, data: 32'h4049_0fdb, to: 1'b0});
    issue(5'b10010, 5'd20, 32'h1, 32'h8000_0002, 32'h1234_5678, wbv);
    @(negedge g_clk);
    vectors++;
    if (unit_sel !== 4'd8 || unit_fma_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL fma_sel: got sel=%0d fma=%0d, required 8/2", unit_sel, unit_fma_sel);
    end
    vectors++;
    if (unit_c !== 32'h1234_5678 || unit_b !== 32'h8000_0002) begin
      miscompares++;
      $display("FAIL fma_operands: got b=%h c=%h, required 80000002/12345678", unit_b, unit_c);
    end
    step();
    unit_done   = 1'b1;
    unit_result = 32'h4049_0fdb;
    step();
    unit_done = 1'b0;
    @(negedge g_clk);
    vectors++;
    if (wb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fma_wb: got wb_valid=%b, required 1", wb_valid);
    end
    step();
  endtask

  task automatic test_timeout();
    logic wbv;
    exp_q.push_back('{rd: 5'd6, data: 32'h7fc0_0000, to: 1'b1});
    issue(5'b00011, 5'd6, 32'h1, 32'h2, 32'h3, wbv);
    repeat (To) step();
    @(negedge g_clk);
    vectors++;
    if (issue_ready !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got ready=%b to=%b, required 0/0", issue_ready, timeout_err);
    end
    step();
    @(negedge g_clk);
    vectors++;
    if (timeout_err !== 1'b1 || wb_valid !== 1'b1 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_exit: got to=%b wb=%b ready=%b, required 1/1/1",
               timeout_err, wb_valid, issue_ready);
    end
    step();
    @(negedge g_clk);
    vectors++;
    if (timeout_err !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 32'h7fc0_0000) begin
      miscompares++;
      $display("FAIL timeout_pulse: got to=%b wb=%b data=%h, required 0/0/7fc00000",
               timeout_err, wb_valid, wb_data);
    end
    step();
  endtask

  task automatic test_flush();
    logic wbv;
    // Flush in WAIT, late done retires the drain silently.
    issue(5'b00000, 5'd7, 32'h1, 32'h2, 32'h3, wbv);
    step();
    flush = 1'b1;
    @(negedge g_clk);
    vectors++;
    if (issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_wait_ready: got %b, required 0", issue_ready);
    end
    step();
    flush = 1'b0;
    @(negedge g_clk);
    vectors++;
    if (issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_busy: got ready=%b, required 0", issue_ready);
    end
    step();
    step();
    unit_done   = 1'b1;
    unit_result = 32'hdead_beef;
    step();
    unit_done = 1'b0;
    @(negedge g_clk);
    vectors++;
    if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_exit: got ready=%b wb=%b, required 1/0", issue_ready, wb_valid);
    end
    step();
    // Flush together with done in WAIT.
    issue(5'b00010, 5'd8, 32'h1, 32'h2, 32'h3, wbv);
    step();
    flush       = 1'b1;
    unit_done   = 1'b1;
    unit_result = 32'h1111_2222;
    step();
    flush     = 1'b0;
    unit_done = 1'b0;
    @(negedge g_clk);
    vectors++;
    if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_with_done: got ready=%b wb=%b, required 1/0", issue_ready, wb_valid);
    end
    step();
    // Flush in IDLE blocks the issue.
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_op    = 5'b00010;
    @(negedge g_clk);
    vectors++;
    if (issue_ready !== 1'b0 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_idle: got ready=%b stall=%b, required 0/1", issue_ready, stall);
    end
    step();
    flush       = 1'b0;
    issue_valid = 1'b0;
    @(negedge g_clk);
    vectors++;
    if (unit_start !== 1'b0 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_idle_block: got start=%b ready=%b, required 0/1",
               unit_start, issue_ready);
    end
    step();
  endtask

  task automatic test_invalid_reset();
    logic wbv;
    comb_result = 32'h1111_1111;
    exp_q.push_back('{rd: 5'd9, data: 32'h7fc0_0000, to: 1'b0});
    issue(5'b00100, 5'd9, 32'h1, 32'h2, 32'h3, wbv);
    @(negedge g_clk);
    vectors++;
    if (unit_sel !== 4'd0 || unit_start !== 1'b0) begin
      miscompares++;
      $display("FAIL invalid_sel: got sel=%0d start=%b, required 0/0", unit_sel, unit_start);
    end
    step();
    step();
    // Reset while a divide is in WAIT.
    issue(5'b00011, 5'd11, 32'haaaa_aaaa, 32'h2, 32'h3, wbv);
    step();
    g_rst_n = 1'b0;
    #1;
    vectors++;
    if (unit_a !== 32'd0 || unit_sel !== 4'd0 || wb_data !== 32'd0 || wb_rd !== 5'd0 ||
        issue_ready !== 1'b1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got a=%h sel=%0d data=%h rd=%0d ready=%b, required zeros/1",
               unit_a, unit_sel, wb_data, wb_rd, issue_ready);
    end
    step();
    g_rst_n = 1'b1;
    step();
    unit_done   = 1'b1;
    unit_result = 32'h5555_5555;
    step();
    unit_done = 1'b0;
    @(negedge g_clk);
    vectors++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0 || issue_ready !== 1'b1 ||
        timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL late_done: got wb=%b data=%h rd=%0d ready=%b, required 0/0/0/1",
               wb_valid, wb_data, wb_rd, issue_ready);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_fsub();
    test_fma();
    test_timeout();
    test_flush();
    test_invalid_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending writebacks, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue and sequencing controller between the decode/execute boundary and the FPU datapath units. It accepts one FP operation at a time through a valid/ready handshake and classifies the opcode as multi-cycle (adder, multiplier, divider, FMA, converters) or single-cycle (sign-inject, compare, class, move). It then holds operands stable, pulses the selected unit, and waits for its done strobe with a timeout. It produces the pipeline stall and a one-cycle registered writeback with destination register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before abort; legal range 2..255.

Ports:
- g_clk  in  1  clock, all state on rising edge.
- g_rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode presents an op.
- issue_ready  out  1  controller accepts an op this cycle.
- issue_op  in  5  FPU select code (fpusel encoding).
- issue_rd  in  5  destination register.
- issue_a, issue_b, issue_c  in  32 each  operands.
- flush  in  1  pipeline flush; kills the op in flight.
- unit_start  out  1  one-cycle start pulse to the selected unit.
- unit_sel  out  4  0 none, 1 add/sub, 2 mul, 3 div, 4 f2i, 5 i2f, 6 f2ui, 7 ui2f, 8 fma.
- unit_fma_sel  out  2  FMA variant, equal to op[1:0].
- unit_a, unit_b, unit_c  out  32 each  registered operands; unit_b has its sign bit inverted for op 00001 (fsub).
- unit_done  in  1  selected unit result strobe.
- unit_result  in  32  multi-cycle unit result.
- comb_result  in  32  single-cycle unit result, valid one cycle after the operands are registered.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  5  destination register for the writeback.
- wb_data  out  32  writeback data.
- stall  out  1  equals ~issue_ready.
- timeout_err  out  1  one-cycle pulse when a timeout abort occurs.

## Operation
- Opcode classes:
  - Multi-cycle: 00000–00011 and 10000–10111.
  - Single-cycle: 00101–01111.
  - Invalid: 00100 and 11000–11111; these take the single-cycle path and write back 32'h7fc00000.
- unit_sel mapping:
  - 00000 and 00001 → 1.
  - 00010 → 2.
  - 00011 → 3.
  - 10000–10011 → 8.
  - 10100 → 5.
  - 10101 → 7.
  - 10110 → 4.
  - 10111 → 6.
  - All other codes → 0.
- States are IDLE, COMB, START, WAIT, DRAIN. issue_ready = (state==IDLE) & ~flush.
- IDLE: on issue_valid & issue_ready, register the op, rd, unit_sel, unit_fma_sel and operands. Go to START if the op is multi-cycle, otherwise to COMB.
- COMB: at the clock edge, wb_data ← comb_result (NaN if the op is invalid), wb_rd ← registered rd, wb_valid ← 1, go to IDLE.
- START: unit_start = 1 for this cycle only. Clear the wait counter. Go to WAIT.
- WAIT: the counter increments every cycle.
  - On unit_done: wb_data ← unit_result, wb_valid ← 1, go to IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 without done: wb_data ← 32'h7fc00000, wb_valid ← 1, timeout_err ← 1, go to IDLE.
- DRAIN: no writeback. Go to IDLE on unit_done or on timeout; timeout_err pulses on the timeout exit.
- Flush handling:
  - In COMB: go to IDLE with no writeback.
  - In START: go to DRAIN.
  - In WAIT with no unit_done: go to DRAIN.
  - In WAIT with unit_done in the same cycle: go to IDLE with no writeback. Flush wins.
  - In IDLE: the issue is blocked for that cycle.
- unit_done is sampled only in WAIT and DRAIN and is ignored in every other state.
- unit_a/b/c, unit_sel and unit_fma_sel hold their values from accept until the next accept.
- Counter width is 8 bits.

## Timing
- Reset (g_rst_n low, asynchronous):
  - state = IDLE, counter = 0.
  - unit_a/b/c = 0, unit_sel = 0, unit_fma_sel = 0.
  - wb_valid = 0, wb_rd = 0, wb_data = 0.
  - unit_start = 0, timeout_err = 0.
  - issue_ready = 1 and stall = 0 (assuming flush is low).
- Reset mid-operation aborts everything. A later unit_done is ignored because state is IDLE.
- Single-cycle path: accept at edge k, COMB during cycle k+1, wb_valid high during cycle k+2. issue_ready is high again in cycle k+2, so back-to-back single-cycle ops sustain one op per 2 cycles.
- Multi-cycle path: accept at edge k, unit_start high in cycle k+1, WAIT from cycle k+2. If unit_done is seen in cycle j, wb_valid is high in cycle j+1 and issue_ready is high in cycle j+1.
- wb_valid and timeout_err are registered and last exactly one cycle. wb_data and wb_rd hold until the next writeback.

## Test plan
- Single-cycle op: reset, then issue op 01010 (feq), rd=3, comb_result=1 → wb_valid pulses exactly 2 cycles after accept with wb_rd=3 and wb_data=1; unit_start never asserts.
- fsub: issue op 00001 with a=0x3F800000, b=0x40000000 → unit_sel=1, unit_b=0xC0000000, one unit_start pulse. Drive unit_done with unit_result=0xBF800000 4 cycles later → wb_data=0xBF800000 one cycle after done; stall is high from the cycle after accept through the done cycle.
- FMA variant: issue op 10010 → unit_sel=8, unit_fma_sel=2, unit_c equals issue_c.
- Timeout: issue op 00011 and never assert unit_done with TIMEOUT_CYCLES=8 → wb_data=0x7FC00000 and timeout_err pulses together; the controller returns to IDLE 8 WAIT cycles after start.
- Flush in WAIT, then a late unit_done → no wb_valid, state goes to DRAIN then IDLE on done. Separately, flush in the same cycle as unit_done → no writeback and IDLE next cycle.
- Invalid op and mid-operation reset: issue op 00100 → wb_data=0x7FC00000. Assert g_rst_n low during WAIT, then pulse unit_done after release → all outputs stay at their reset values and no writeback occurs.
